// File: rtl/lpc_host_if.sv
// ============================================================================
//  Module   : lpc_host_if
//  Brief    : Local request handshake plus LPC LAD/LFRAME# signals for lpc_host
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface lpc_host_if;
  // local request side
  logic        req_i;
  logic        wr_i;
  logic [15:0] addr_i;
  logic [7:0]  wdata_i;
  logic        ready_o;
  logic        done_o;
  logic        err_o;
  logic [7:0]  rdata_o;
  // LPC bus side
  logic        lframe_o;
  logic [3:0]  lad_o;
  logic        lad_oe_o;
  logic [3:0]  lad_i;

  // requester / bus model: drives requests and the sampled LAD value
  modport master (
    output req_i, wr_i, addr_i, wdata_i, lad_i,
    input  ready_o, done_o, err_o, rdata_o, lframe_o, lad_o, lad_oe_o
  );

  // lpc_host itself
  modport slave (
    input  req_i, wr_i, addr_i, wdata_i, lad_i,
    output ready_o, done_o, err_o, rdata_o, lframe_o, lad_o, lad_oe_o
  );
endinterface

`default_nettype wire

// File: rtl/lpc_host.sv
// ============================================================================
//  Module   : lpc_host
//  Brief    : LPC initiator for single-byte TPM read/write cycles
//             (START, CYCTYPE, ADDR, DATA, TAR, SYNC) with wait-state timeouts
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module lpc_host #(
  parameter int SYNC_SHORT_MAX = 16,
  parameter int SYNC_LONG_MAX  = 1024,
  parameter int NOSYNC_MAX     = 4
) (
  input  wire logic   clk_i,
  input  wire logic   rst_i,
  lpc_host_if.slave   bus
);

  localparam logic [3:0] c_st_idle  = 4'd0;
  localparam logic [3:0] c_st_start = 4'd1;
  localparam logic [3:0] c_st_cyc   = 4'd2;
  localparam logic [3:0] c_st_addr  = 4'd3;
  localparam logic [3:0] c_st_wdata = 4'd4;
  localparam logic [3:0] c_st_tar1  = 4'd5;
  localparam logic [3:0] c_st_tar2  = 4'd6;
  localparam logic [3:0] c_st_sync  = 4'd7;
  localparam logic [3:0] c_st_rdata = 4'd8;
  localparam logic [3:0] c_st_ftar1 = 4'd9;
  localparam logic [3:0] c_st_ftar2 = 4'd10;
  localparam logic [3:0] c_st_abort = 4'd11;

  // wait counter must hold the largest of the three limits
  localparam int c_max_sl = (SYNC_SHORT_MAX > SYNC_LONG_MAX) ? SYNC_SHORT_MAX : SYNC_LONG_MAX;
  localparam int c_max    = (c_max_sl > NOSYNC_MAX) ? c_max_sl : NOSYNC_MAX;
  localparam int c_cw     = $clog2(c_max + 1);
  localparam logic [c_cw-1:0] c_short  = SYNC_SHORT_MAX[c_cw-1:0];
  localparam logic [c_cw-1:0] c_long   = SYNC_LONG_MAX[c_cw-1:0];
  localparam logic [c_cw-1:0] c_nosync = NOSYNC_MAX[c_cw-1:0];

  logic [3:0]      r_state;
  logic            r_ready, r_done, r_err, r_lframe, r_oe, r_sticky;
  logic [3:0]      r_lad, r_last, r_rlo;
  logic [7:0]      r_rdata, r_wdata;
  logic [15:0]     r_addr;
  logic            r_wr;
  logic [1:0]      r_nib;     // address/data nibble index, reused as ABORT clock count
  logic [c_cw-1:0] r_cnt;     // consecutive clocks of the current SYNC code, 0 = none yet

  logic [c_cw-1:0] w_cnt_n;
  logic [3:0]      w_addr_nib;
  logic            w_proceed, w_abort, w_nosync;

  assign bus.ready_o  = r_ready;
  assign bus.done_o   = r_done;
  assign bus.err_o    = r_err;
  assign bus.rdata_o  = r_rdata;
  assign bus.lframe_o = r_lframe;
  assign bus.lad_o    = r_lad;
  assign bus.lad_oe_o = r_oe;

  // SYNC decode: run length of the sampled code and the resulting decision
  always_comb begin
    w_cnt_n   = ((r_cnt != '0) && (bus.lad_i == r_last)) ? r_cnt + 1'b1 : {{(c_cw-1){1'b0}}, 1'b1};
    w_proceed = (bus.lad_i == 4'h0) || (bus.lad_i == 4'hA);
    w_nosync  = (bus.lad_i == 4'hF) && (w_cnt_n == c_nosync);
    w_abort   = ((bus.lad_i == 4'h5) && (w_cnt_n == c_short)) ||
                ((bus.lad_i == 4'h6) && (w_cnt_n == c_long))  ||
                !((bus.lad_i == 4'h0) || (bus.lad_i == 4'hA) || (bus.lad_i == 4'h5) ||
                  (bus.lad_i == 4'h6) || (bus.lad_i == 4'hF));
    case (r_nib)
      2'd0:    w_addr_nib = r_addr[11:8];
      2'd1:    w_addr_nib = r_addr[7:4];
      2'd2:    w_addr_nib = r_addr[3:0];
      default: w_addr_nib = r_addr[15:12];
    endcase
  end

  // frame sequencer; every output is registered alongside the state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= c_st_idle;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= 8'h00;
      r_lframe <= 1'b1;
      r_lad    <= 4'hF;
      r_oe     <= 1'b0;
      r_sticky <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= 16'h0000;
      r_wdata  <= 8'h00;
      r_nib    <= 2'd0;
      r_cnt    <= '0;
      r_last   <= 4'h0;
      r_rlo    <= 4'h0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (bus.req_i) begin
            r_wr     <= bus.wr_i;
            r_addr   <= bus.addr_i;
            r_wdata  <= bus.wdata_i;
            r_ready  <= 1'b0;
            r_sticky <= 1'b0;
            r_lframe <= 1'b0;
            r_lad    <= 4'h5;
            r_oe     <= 1'b1;
            r_state  <= c_st_start;
          end
        end
        c_st_start: begin
          r_lframe <= 1'b1;
          r_lad    <= r_wr ? 4'h2 : 4'h0;
          r_state  <= c_st_cyc;
        end
        c_st_cyc: begin
          r_lad   <= r_addr[15:12];
          r_nib   <= 2'd0;
          r_state <= c_st_addr;
        end
        c_st_addr: begin
          if (r_nib == 2'd3) begin
            r_nib <= 2'd0;
            if (r_wr) begin
              r_lad   <= r_wdata[3:0];
              r_state <= c_st_wdata;
            end else begin
              r_lad   <= 4'hF;
              r_state <= c_st_tar1;
            end
          end else begin
            r_lad <= w_addr_nib;
            r_nib <= r_nib + 2'd1;
          end
        end
        c_st_wdata: begin
          if (r_nib == 2'd0) begin
            r_lad <= r_wdata[7:4];
            r_nib <= 2'd1;
          end else begin
            r_lad   <= 4'hF;
            r_state <= c_st_tar1;
          end
        end
        c_st_tar1: begin
          r_oe    <= 1'b0;
          r_state <= c_st_tar2;
        end
        c_st_tar2: begin
          r_cnt   <= '0;
          r_state <= c_st_sync;
        end
        c_st_sync: begin
          r_cnt  <= w_cnt_n;
          r_last <= bus.lad_i;
          if (w_proceed) begin
            if (bus.lad_i == 4'hA) r_sticky <= 1'b1;
            r_nib   <= 2'd0;
            r_state <= r_wr ? c_st_ftar1 : c_st_rdata;
          end else if (w_abort) begin
            r_lframe <= 1'b0;
            r_lad    <= 4'hF;
            r_oe     <= 1'b1;
            r_nib    <= 2'd0;
            r_state  <= c_st_abort;
          end else if (w_nosync) begin
            r_sticky <= 1'b1;
            r_state  <= c_st_ftar2;
          end
        end
        c_st_rdata: begin
          if (r_nib == 2'd0) begin
            r_rlo <= bus.lad_i;
            r_nib <= 2'd1;
          end else begin
            r_rdata <= {bus.lad_i, r_rlo};
            r_state <= c_st_ftar1;
          end
        end
        c_st_ftar1: begin
          r_state <= c_st_ftar2;
        end
        c_st_ftar2: begin
          r_done  <= 1'b1;
          r_err   <= r_sticky;
          r_ready <= 1'b1;
          r_state <= c_st_idle;
        end
        c_st_abort: begin
          if (r_nib == 2'd3) begin
            r_lframe <= 1'b1;
            r_oe     <= 1'b0;
            r_done   <= 1'b1;
            r_err    <= 1'b1;
            r_ready  <= 1'b1;
            r_state  <= c_st_idle;
          end else begin
            r_nib <= r_nib + 2'd1;
          end
        end
        default: begin
          r_lframe <= 1'b1;
          r_oe     <= 1'b0;
          r_lad    <= 4'hF;
          r_ready  <= 1'b1;
          r_state  <= c_st_idle;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
